// File: rtl/pipe_load_ctrl.sv
// pipe_load_ctrl
// ---------------------------------------------------------------------------
// Pipeline sequencing controller for a five-register in-order pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it produces one coherent set
// of register load enables and bubble (flush) strobes. It resolves, in order
// of precedence:
//   - data-memory wait states (whole-pipeline freeze),
//   - taken branches / jumps resolved in EX (two-bubble flush),
//   - multi-cycle multiply/divide occupancy of EX,
//   - load-use hazards between EX and ID (one-cycle stall).
//
// Optional feature (compile-time macro PIPE_STALL_PERF_EN):
//   Adds a 32-bit free-running counter of front-end stall cycles
//   (cycles out of reset in which pc_load is low), exposed on stall_cycles.
//   It wraps modulo 2^32 and is cleared by rst.
//
// Ports
//   clk               clock; all state updates on the rising edge
//   rst               synchronous active-high reset; forces all outputs to 0
//   id_rs, id_rt      source register specifiers of the instruction in ID
//   id_uses_rt        ID instruction actually reads id_rt
//   ex_rd             destination register of the instruction in EX
//   ex_mem_read       EX instruction is a load
//   ex_branch_taken   taken branch / jump resolved in EX
//   ex_mdu_op         EX instruction is a multiply/divide
//   mem_wait          data memory not ready; freeze the pipeline
//   pc_load .. memwb_load   per-register load enables
//   ifid_flush, idex_flush  load an all-zero bubble into that register
//   mdu_start         one-cycle start pulse to the multiply/divide unit
//   mdu_result_sel    EX/MEM captures the MDU result this cycle
//   stall_cycles      (PIPE_STALL_PERF_EN only) stall-cycle counter
// ---------------------------------------------------------------------------
module pipe_load_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,

  // Hazard information from decode / execute
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_op,
  input  logic                  mem_wait,

  // Pipeline register controls
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  idex_load,
  output logic                  exmem_load,
  output logic                  memwb_load,
  output logic                  ifid_flush,
  output logic                  idex_flush,

  // Multiply/divide unit handshake
  output logic                  mdu_start,
  output logic                  mdu_result_sel
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // -------------------------------------------------------------------------
  // Types and constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMduBusy = 2'b01,
    StMduDone = 2'b10
  } state_e;

  // Counter preload: the busy phase lasts cnt_q+1 cycles, so MDU_CYCLES-1
  // yields exactly MDU_CYCLES busy cycles before MDU_DONE.
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MDU_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // real dependency.
  logic rd_nonzero;
  logic rs_match;
  logic rt_match;
  logic load_use;

  always_comb begin
    rd_nonzero = (ex_rd != '0);
    rs_match   = (ex_rd == id_rs);
    rt_match   = id_uses_rt && (ex_rd == id_rt);
    load_use   = ex_mem_read && rd_nonzero && (rs_match || rt_match);
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_load        = 1'b0;
    ifid_load      = 1'b0;
    idex_load      = 1'b0;
    exmem_load     = 1'b0;
    memwb_load     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    mdu_start      = 1'b0;
    mdu_result_sel = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          // Full freeze; the EX instruction is re-evaluated once memory is ready.
        end else if (ex_branch_taken) begin
          // Wrong-path instructions in IF/ID and ID/EX become bubbles.
          pc_load    = 1'b1;
          ifid_load  = 1'b1;
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ex_mdu_op) begin
          // Hold the MDU instruction in EX; let older instructions drain.
          mdu_start  = 1'b1;
          memwb_load = 1'b1;
          state_d    = StMduBusy;
          cnt_d      = CntInit;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject a bubble behind the load.
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_load    = 1'b1;
          ifid_load  = 1'b1;
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
        end
      end

      StMduBusy: begin
        // The MDU runs on its own, so the countdown ignores mem_wait; only
        // the MEM/WB drain is gated by memory readiness.
        memwb_load = !mem_wait;
        if (cnt_q == '0) begin
          state_d = StMduDone;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StMduDone: begin
        if (!mem_wait) begin
          pc_load        = 1'b1;
          ifid_load      = 1'b1;
          idex_load      = 1'b1;
          exmem_load     = 1'b1;
          memwb_load     = 1'b1;
          mdu_result_sel = 1'b1;
          state_d        = StRun;
        end
      end

      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase

    // Reset dominates every output, regardless of state.
    if (rst) begin
      pc_load        = 1'b0;
      ifid_load      = 1'b0;
      idex_load      = 1'b0;
      exmem_load     = 1'b0;
      memwb_load     = 1'b0;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      mdu_start      = 1'b0;
      mdu_result_sel = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Optional stall-cycle performance counter
  // -------------------------------------------------------------------------
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!pc_load) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
